secded_dec_pipe: RTL and testbench
==================================

# secded_dec_pipe

Pipelined, parametrised Hsiao SEC-DED decoder with valid/ready handshakes and saturating error-event counters. It generalises the single-cycle combinational (39,32) decoder to 32- or 64-bit data. It sits between memory read data and the consumer, and offers full throughput with backpressure. Counters feed the error-logging/scrub controller.

## Interface
- `DW`, 32: data width; only 32 and 64 are legal, and any other value is an elaboration error.
- `CW`, derived: check width; 7 when DW=32, 8 when DW=64; not overridable.
- `CNT_W`, 16: width of each error counter.
- `clk`  in  1: clock; the block uses this one clock only.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: codeword valid.
- `in_ready`  out  1: decoder can accept a codeword.
- `in_cw`  in  DW+CW: codeword; data in [DW-1:0], check bits in [DW+CW-1:DW].
- `corr_en`  in  1: 1 corrects data; 0 passes data through raw but still computes flags.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts the result.
- `out_data`  out  DW: corrected data (or raw data when `corr_en` was 0).
- `out_syn`  out  CW: syndrome of this word.
- `out_sgl`  out  1: a single-bit error occurred in a data or check bit.
- `out_unc`  out  1: the error is uncorrectable (nonzero syndrome that is not a column).
- `cnt_clr`  in  1: synchronous clear of both counters.
- `sgl_cnt`  out  CNT_W: count of single-bit events.
- `unc_cnt`  out  CNT_W: count of uncorrectable events.

## Operation
- **Stage 1 (S1):**
  - Syndrome = XOR over set columns of H, XORed with the check bits.
  - Registered together with the raw codeword and the sampled `corr_en`.
- **Stage 2 (S2), classification:**
  - Syndrome 0: clean.
  - Syndrome equals data column i: flip data bit i (only if `corr_en`), `out_sgl`=1.
  - Syndrome is weight 1: check-bit error; data unchanged, `out_sgl`=1.
  - Any other nonzero syndrome (all even-weight, plus odd-weight non-columns): `out_unc`=1, data unchanged.
  - `out_sgl` and `out_unc` are never both 1.
- **Handshake:**
  - Each stage holds a valid bit. A stage loads when it is empty or the stage downstream advances.
  - `in_ready` = !s1_valid || s1_adv.
  - Output is S2. It holds stable while `out_valid` && !`out_ready`.
  - No combinational path from `in_valid` to `out_valid`.
- **Counters:**
  - Increment on an output handshake with the corresponding flag set.
  - Saturate at 2^CNT_W-1.
  - If `cnt_clr` coincides with an increment, the clear wins and the result is 0.

## Timing
- **Reset values:** all of these are 0: valid bits, `out_valid`, `out_data`, `out_syn`, `out_sgl`, `out_unc`, `sgl_cnt`, `unc_cnt`.
- **In and after reset:** `in_ready` is 1 after reset deassertion and 1 while in reset.
- **Reset mid-operation:** in-flight words are discarded; nothing is emitted for them.
- **Latency:** 2 cycles from the input handshake in cycle t to `out_valid` in cycle t+2, with no stall.
- **Throughput:** 1 word/cycle while `out_ready` is held 1.
- **Full pipeline:** with both stages full and `out_ready`=0, `in_ready`=0 in the same cycle.
- **Input under stall:** `in_cw` is not required to be held once it is accepted.
- **`corr_en`:** sampled with its word.
- **Counter visibility:** an updated count is visible the cycle after the handshake.

## Structure
- **Package `secded_pkg`:**
  - `H32_COLS[32]` (7-bit) and `H64_COLS[64]` (8-bit) Hsiao column constants.
  - `H32_COLS[0]` = 7'b0000111, `H32_COLS[1]` = 7'b0001011.
  - Function `cw_of(DW)`.
  - Enum `err_kind_t` {CLEAN, SGL_DATA, SGL_CHK, UNC}.
- **Sub-module `secded_syn_calc`:** the combinational syndrome generator, parametrised on DW. It is reused by the encoder (with the check input tied to 0).
- **Top level:** holds the stage registers, the classifier/corrector and the counters.

## Test plan
1. **Clean word:** DW=32, data 32'hDEADBEEF with correct check bits, `out_ready`=1 → output at t+2, data unchanged, syn 0, flags 0, counters unchanged.
2. **Data single-bit error:** data bit 0 flipped → `out_syn`=7'h07, `out_data` corrected, `out_sgl`=1, `sgl_cnt`=1. Repeat with `corr_en`=0 → raw data out, `out_sgl`=1.
3. **Check-bit and double errors:**
   - Check bit 0 flipped → syn 7'h01, data unchanged, `out_sgl`=1.
   - Bits 0 and 1 flipped → syn 7'h0C, `out_unc`=1, `unc_cnt`=1.
4. **Backpressure:**
   - Stream 10 words with `out_ready` toggling randomly → in-order delivery, no loss or duplication, stalled outputs stable.
   - `in_ready`=0 while both stages are full and stalled.
5. **Counter saturation and clear:**
   - CNT_W=2: 5 single-bit errors → `sgl_cnt` stays at 3.
   - `cnt_clr` asserted in the same cycle as an error handshake → 0.
6. **Reset and DW=64:**
   - `rst_n` low with both stages full → all outputs 0 immediately, `in_ready`=1, no stale output after release.
   - DW=64: exhaustive single-bit flips across all 72 bits → each is corrected or flagged `out_sgl`.
   - DW=64: 200 random double flips → all flagged `out_unc`.

Source files
------------

// File: rtl/secded_pkg.sv
// Shared constants and types for the Hsiao SEC-DED decoder family.
// Columns are odd-weight and distinct: all weight-3 patterns in ascending
// order, then the smallest weight-5 patterns for the 64-bit code.
package secded_pkg;

  typedef enum logic [1:0] {CLEAN, SGL_DATA, SGL_CHK, UNC} err_kind_t;

  localparam logic [6:0] H32_COLS [32] = '{
    7'h07, 7'h0B, 7'h0D, 7'h0E, 7'h13, 7'h15, 7'h16, 7'h19,
    7'h1A, 7'h1C, 7'h23, 7'h25, 7'h26, 7'h29, 7'h2A, 7'h2C,
    7'h31, 7'h32, 7'h34, 7'h38, 7'h43, 7'h45, 7'h46, 7'h49,
    7'h4A, 7'h4C, 7'h51, 7'h52, 7'h54, 7'h58, 7'h61, 7'h62
  };

  localparam logic [7:0] H64_COLS [64] = '{
    8'h07, 8'h0B, 8'h0D, 8'h0E, 8'h13, 8'h15, 8'h16, 8'h19,
    8'h1A, 8'h1C, 8'h23, 8'h25, 8'h26, 8'h29, 8'h2A, 8'h2C,
    8'h31, 8'h32, 8'h34, 8'h38, 8'h43, 8'h45, 8'h46, 8'h49,
    8'h4A, 8'h4C, 8'h51, 8'h52, 8'h54, 8'h58, 8'h61, 8'h62,
    8'h64, 8'h68, 8'h70, 8'h83, 8'h85, 8'h86, 8'h89, 8'h8A,
    8'h8C, 8'h91, 8'h92, 8'h94, 8'h98, 8'hA1, 8'hA2, 8'hA4,
    8'hA8, 8'hB0, 8'hC1, 8'hC2, 8'hC4, 8'hC8, 8'hD0, 8'hE0,
    8'h1F, 8'h2F, 8'h37, 8'h3B, 8'h3D, 8'h3E, 8'h4F, 8'h57
  };

  // Check width for a given data width
  function automatic int cw_of(input int dw);
    return (dw == 64) ? 8 : 7;
  endfunction

  // H-matrix column for data bit i, zero-extended to 8 bits
  function automatic logic [7:0] h_col(input int dw, input int i);
    if (dw == 64) return H64_COLS[i];
    return {1'b0, H32_COLS[i]};
  endfunction

endpackage

// File: rtl/secded_syn_calc.sv
// Combinational syndrome generator: XOR of the H columns selected by the data
// bits, folded with the supplied check bits. With chk tied to 0 it produces
// the check bits for encoding.
module secded_syn_calc
  import secded_pkg::*;
#(
  parameter  int DW = 32,
  localparam int CW = cw_of(DW)
) (
  input  logic [DW-1:0] data,
  input  logic [CW-1:0] chk,
  output logic [CW-1:0] syn
);

  // Accumulate column parity over set data bits
  always_comb begin
    syn = chk;
    for (int i = 0; i < DW; i++) begin
      if (data[i]) syn = syn ^ CW'(h_col(DW, i));
    end
  end

endmodule

// File: rtl/secded_dec_pipe.sv
// Two-stage pipelined Hsiao SEC-DED decoder with valid/ready flow control
// and saturating single/uncorrectable event counters.
module secded_dec_pipe
  import secded_pkg::*;
#(
  parameter  int DW    = 32,
  parameter  int CNT_W = 16,
  localparam int CW    = cw_of(DW)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW+CW-1:0] in_cw,
  input  logic             corr_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [CW-1:0]    out_syn,
  output logic             out_sgl,
  output logic             out_unc,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] sgl_cnt,
  output logic [CNT_W-1:0] unc_cnt
);

  if (DW != 32 && DW != 64) begin : g_dw_check
    $error("secded_dec_pipe: DW must be 32 or 64, got %0d", DW);
  end

  logic [CW-1:0] syn_p0;
  logic          vld_p1;
  logic [DW-1:0] data_p1;
  logic [CW-1:0] syn_p1;
  logic          corr_p1;
  err_kind_t     kind_p1;
  logic [DW-1:0] flip_p1;
  logic [DW-1:0] data_fix_p1;
  logic          s2_adv;
  logic          out_hs;

  // ---- stage 0 -> 1: syndrome from the incoming codeword ----
  secded_syn_calc #(.DW(DW)) u_syn (
    .data (in_cw[DW-1:0]),
    .chk  (in_cw[DW+CW-1:DW]),
    .syn  (syn_p0)
  );

  // S2 accepts when empty or draining; S1 accepts when empty or moving on
  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !vld_p1 || s2_adv;
  assign out_hs   = out_valid && out_ready;

  // S1 occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        vld_p1 <= 1'b0;
    else if (in_ready) vld_p1 <= in_valid;
  end

  // S1 payload; meaningful only while vld_p1 is set
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      data_p1 <= in_cw[DW-1:0];
      syn_p1  <= syn_p0;
      corr_p1 <= corr_en;
    end
  end

  // ---- stage 1 -> 2: classify syndrome and correct ----
  // Classify: zero, weight-1 (check bit), data column match, else uncorrectable
  always_comb begin
    kind_p1 = CLEAN;
    flip_p1 = '0;
    if (syn_p1 == '0) begin
      kind_p1 = CLEAN;
    end else if ($onehot(syn_p1)) begin
      kind_p1 = SGL_CHK;
    end else begin
      kind_p1 = UNC;
      for (int i = 0; i < DW; i++) begin
        if (syn_p1 == CW'(h_col(DW, i))) begin
          kind_p1    = SGL_DATA;
          flip_p1[i] = 1'b1;
        end
      end
    end
  end

  assign data_fix_p1 = corr_p1 ? (data_p1 ^ flip_p1) : data_p1;

  // S2 output register; holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_syn   <= '0;
      out_sgl   <= 1'b0;
      out_unc   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_data <= data_fix_p1;
        out_syn  <= syn_p1;
        out_sgl  <= (kind_p1 == SGL_DATA) || (kind_p1 == SGL_CHK);
        out_unc  <= (kind_p1 == UNC);
      end
    end
  end

  // ---- error event counters: clear has priority, saturate at all-ones ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgl_cnt <= '0;
      unc_cnt <= '0;
    end else if (cnt_clr) begin
      sgl_cnt <= '0;
      unc_cnt <= '0;
    end else if (out_hs) begin
      if (out_sgl && sgl_cnt != '1) sgl_cnt <= sgl_cnt + CNT_W'(1);
      if (out_unc && unc_cnt != '1) unc_cnt <= unc_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_secded_dec_pipe.sv
// Testbench: a 32-bit decoder with 2-bit counters and a 64-bit decoder with
// 16-bit counters, each compared against an arithmetic SEC-DED model.
module tb_secded_dec_pipe;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  syn;
    bit          sgl;
    bit          unc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  // 32-bit instance signals
  logic        a_in_valid = 0, a_in_ready, a_corr_en = 1, a_out_valid, a_out_ready = 0;
  logic        a_cnt_clr = 0, a_out_sgl, a_out_unc;
  logic [38:0] a_in_cw = '0;
  logic [31:0] a_out_data;
  logic [6:0]  a_out_syn;
  logic [1:0]  a_sgl_cnt, a_unc_cnt;
  // 64-bit instance signals
  logic        b_in_valid = 0, b_in_ready, b_corr_en = 1, b_out_valid, b_out_ready = 0;
  logic        b_cnt_clr = 0, b_out_sgl, b_out_unc;
  logic [71:0] b_in_cw = '0;
  logic [63:0] b_out_data;
  logic [7:0]  b_out_syn;
  logic [15:0] b_sgl_cnt, b_unc_cnt;

  secded_dec_pipe #(.DW(32), .CNT_W(2)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_cw(a_in_cw), .corr_en(a_corr_en), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_syn(a_out_syn),
    .out_sgl(a_out_sgl), .out_unc(a_out_unc), .cnt_clr(a_cnt_clr),
    .sgl_cnt(a_sgl_cnt), .unc_cnt(a_unc_cnt));

  secded_dec_pipe #(.DW(64), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_cw(b_in_cw), .corr_en(b_corr_en), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_syn(b_out_syn),
    .out_sgl(b_out_sgl), .out_unc(b_out_unc), .cnt_clr(b_cnt_clr),
    .sgl_cnt(b_sgl_cnt), .unc_cnt(b_unc_cnt));

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] hc32 [32];
  logic [7:0] hc64 [64];

  // Hsiao columns rebuilt from the construction rule (odd weight, ascending)
  task automatic build_cols();
    int n;
    n = 0;
    for (int v = 1; v < 128; v++)
      if ($countones(v[6:0]) == 3 && n < 32) begin hc32[n] = v[7:0]; n++; end
    n = 0;
    for (int w = 3; w <= 5; w += 2)
      for (int v = 1; v < 256; v++)
        if ($countones(v[7:0]) == w && n < 64) begin hc64[n] = v[7:0]; n++; end
  endtask

  function automatic logic [7:0] col(input int dw, input int i);
    if (dw == 32) return hc32[i];
    return hc64[i];
  endfunction

  function automatic logic [7:0] enc(input logic [63:0] d, input int dw);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < dw; i++) if (d[i]) c ^= col(dw, i);
    return c;
  endfunction

  function automatic exp_t ref_dec(input logic [71:0] cw, input int dw, input bit corr);
    exp_t e;
    logic [7:0] s;
    int hits;
    e.d = (dw == 32) ? {32'b0, cw[31:0]} : cw[63:0];
    s   = (dw == 32) ? {1'b0, cw[38:32]} : cw[71:64];
    s   = s ^ enc(e.d, dw);
    e.syn = s; e.sgl = 0; e.unc = 0;
    if (s != 0) begin
      if ($countones(s) == 1) e.sgl = 1;
      else begin
        hits = 0;
        for (int i = 0; i < dw; i++)
          if (s == col(dw, i)) begin hits++; if (corr) e.d[i] = ~e.d[i]; end
        if (hits == 1) e.sgl = 1; else e.unc = 1;
      end
    end
    return e;
  endfunction

  function automatic logic [38:0] mk_a(input logic [31:0] d);
    logic [7:0] c;
    c = enc({32'b0, d}, 32);
    return {c[6:0], d};
  endfunction

  function automatic logic [71:0] mk_b(input logic [63:0] d);
    return {enc(d, 64), d};
  endfunction

  // ---------------- ready drivers ----------------
  int a_mode = 0, b_mode = 0;   // 0: hold low, 1: hold high, 2: random
  always @(posedge clk) begin
    #1;
    a_out_ready = (a_mode == 2) ? 1'($urandom_range(0, 1)) : (a_mode == 1);
    b_out_ready = (b_mode == 2) ? 1'($urandom_range(0, 1)) : (b_mode == 1);
  end

  // ---------------- scoreboards / monitors ----------------
  exp_t qa[$], qb[$];
  exp_t a_e, b_e;
  int a_msgl = 0, a_munc = 0, b_msgl = 0, b_munc = 0;
  bit a_held = 0, b_held = 0;
  logic [95:0] a_hold_v, b_hold_v;
  int a_stall = 0, b_stall = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete(); a_msgl = 0; a_munc = 0; a_held = 0;
    end else begin
      check("a_sgl_cnt", 96'(a_sgl_cnt), 96'(a_msgl));
      check("a_unc_cnt", 96'(a_unc_cnt), 96'(a_munc));
      if (a_held)
        check("a_stall_hold", {54'b0, a_out_valid, a_out_sgl, a_out_unc, a_out_syn, a_out_data}, a_hold_v);
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) check("a_extra_out", 96'(a_out_valid), 96'(0));
        else begin
          a_e = qa.pop_front();
          check("a_data", 96'(a_out_data), 96'(a_e.d));
          check("a_syn", 96'(a_out_syn), 96'(a_e.syn));
          check("a_flags", 96'({a_out_sgl, a_out_unc}), 96'({a_e.sgl, a_e.unc}));
          if (a_e.sgl && a_msgl < 3) a_msgl++;
          if (a_e.unc && a_munc < 3) a_munc++;
        end
      end
      if (a_cnt_clr) begin a_msgl = 0; a_munc = 0; end
      a_held   = a_out_valid && !a_out_ready;
      a_hold_v = {54'b0, a_out_valid, a_out_sgl, a_out_unc, a_out_syn, a_out_data};
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      qb.delete(); b_msgl = 0; b_munc = 0; b_held = 0;
    end else begin
      check("b_sgl_cnt", 96'(b_sgl_cnt), 96'(b_msgl));
      check("b_unc_cnt", 96'(b_unc_cnt), 96'(b_munc));
      if (b_held)
        check("b_stall_hold", {21'b0, b_out_valid, b_out_sgl, b_out_unc, b_out_syn, b_out_data}, b_hold_v);
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) check("b_extra_out", 96'(b_out_valid), 96'(0));
        else begin
          b_e = qb.pop_front();
          check("b_data", 96'(b_out_data), 96'(b_e.d));
          check("b_syn", 96'(b_out_syn), 96'(b_e.syn));
          check("b_flags", 96'({b_out_sgl, b_out_unc}), 96'({b_e.sgl, b_e.unc}));
          if (b_e.sgl && b_msgl < 65535) b_msgl++;
          if (b_e.unc && b_munc < 65535) b_munc++;
        end
      end
      if (b_cnt_clr) begin b_msgl = 0; b_munc = 0; end
      b_held   = b_out_valid && !b_out_ready;
      b_hold_v = {21'b0, b_out_valid, b_out_sgl, b_out_unc, b_out_syn, b_out_data};
    end
  end

  // ---------------- drivers (called at posedge+1, return at posedge+1) ----------------
  task automatic send_a(input logic [38:0] cw, input bit corr);
    int w;
    a_in_cw = cw; a_corr_en = corr; a_in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!a_in_ready && w < 200) begin w++; @(negedge clk); end
    if (!a_in_ready) begin
      check("a_in_rdy_timeout", 96'(a_in_ready), 96'(1));
      a_in_valid = 1'b0;
    end else qa.push_back(ref_dec(72'(cw), 32, corr));
    a_stall += w;
    @(posedge clk); #1;
  endtask

  task automatic send_b(input logic [71:0] cw, input bit corr);
    int w;
    b_in_cw = cw; b_corr_en = corr; b_in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!b_in_ready && w < 200) begin w++; @(negedge clk); end
    if (!b_in_ready) begin
      check("b_in_rdy_timeout", 96'(b_in_ready), 96'(1));
      b_in_valid = 1'b0;
    end else qb.push_back(ref_dec(cw, 64, corr));
    b_stall += w;
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int w;
    w = 0;
    while ((qa.size() != 0 || qb.size() != 0) && w < 300) begin @(posedge clk); w++; end
    #1;
    check({tag, "_drain"}, 96'(qa.size() + qb.size()), 96'(0));
  endtask

  // Single word into an idle 32-bit pipe with out_ready high; checks latency and constants
  task automatic directed_a(input string tag, input logic [38:0] cw, input bit corr,
                            input logic [31:0] ed, input logic [6:0] es, input bit esg, input bit eun);
    send_a(cw, corr);
    a_in_valid = 1'b0;
    @(negedge clk) check({tag, "_lat_t1"}, 96'(a_out_valid), 96'(0));
    @(negedge clk) check({tag, "_lat_t2"}, 96'(a_out_valid), 96'(1));
    check({tag, "_data"}, 96'(a_out_data), 96'(ed));
    check({tag, "_syn"}, 96'(a_out_syn), 96'(es));
    check({tag, "_flags"}, 96'({a_out_sgl, a_out_unc}), 96'({esg, eun}));
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] d32;
    logic [63:0] d64;
    logic [71:0] cwb;
    logic [38:0] cwa;
    int p1, p2;

    build_cols();

    // Reset values
    #1;
    check("rst_a_outs", {38'b0, a_out_valid, a_out_sgl, a_out_unc, a_out_syn, a_out_data, a_sgl_cnt, a_unc_cnt}, 96'(0));
    check("rst_b_outs", {53'b0, b_out_valid, b_out_sgl, b_out_unc, b_out_syn, b_sgl_cnt, b_unc_cnt}, 96'(0));
    check("rst_b_data", 96'(b_out_data), 96'(0));
    check("rst_in_ready", 96'({a_in_ready, b_in_ready}), 96'(2'b11));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("post_rst_in_ready", 96'({a_in_ready, b_in_ready}), 96'(2'b11));
    a_mode = 1; b_mode = 1;
    @(posedge clk); #1;

    // Clean word
    cwa = mk_a(32'hDEADBEEF);
    directed_a("clean", cwa, 1'b1, 32'hDEADBEEF, 7'h00, 1'b0, 1'b0);
    check("clean_cnts", 96'({a_sgl_cnt, a_unc_cnt}), 96'(0));

    // Data bit 0 flipped, corrected then raw
    directed_a("d0_corr", cwa ^ 39'h1, 1'b1, 32'hDEADBEEF, 7'h07, 1'b1, 1'b0);
    check("d0_corr_cnt", 96'(a_sgl_cnt), 96'(1));
    directed_a("d0_raw", cwa ^ 39'h1, 1'b0, 32'hDEADBEEE, 7'h07, 1'b1, 1'b0);
    check("d0_raw_cnt", 96'(a_sgl_cnt), 96'(2));

    // Check bit 0 flipped; data bits 0 and 1 flipped
    directed_a("chk0", cwa ^ (39'h1 << 32), 1'b1, 32'hDEADBEEF, 7'h01, 1'b1, 1'b0);
    directed_a("dbl01", cwa ^ 39'h3, 1'b1, 32'hDEADBEEC, 7'h0C, 1'b0, 1'b1);
    check("dbl01_cnts", 96'({a_sgl_cnt, a_unc_cnt}), 96'({2'd3, 2'd1}));

    // Counter clear, then saturation with five single-bit errors
    a_cnt_clr = 1'b1; @(posedge clk); #1 a_cnt_clr = 1'b0;
    check("clr_cnts", 96'({a_sgl_cnt, a_unc_cnt}), 96'(0));
    for (int k = 0; k < 5; k++) begin
      d32 = $urandom;
      send_a(mk_a(d32) ^ (39'h1 << $urandom_range(0, 38)), 1'b1);
    end
    a_in_valid = 1'b0;
    drain("sat");
    check("sat_sgl_cnt", 96'(a_sgl_cnt), 96'(3));

    // Clear coinciding with an error handshake
    d32 = $urandom;
    send_a(mk_a(d32) ^ (39'h1 << 5), 1'b1);
    a_in_valid = 1'b0;
    @(posedge clk); #1;
    check("clrhs_vld", 96'({a_out_valid, a_out_sgl}), 96'(2'b11));
    a_cnt_clr = 1'b1;
    @(posedge clk); #1 a_cnt_clr = 1'b0;
    check("clrhs_cnt", 96'(a_sgl_cnt), 96'(0));

    // Backpressure: 10 random words with random out_ready
    a_mode = 2;
    for (int k = 0; k < 10; k++) begin
      d32 = $urandom;
      cwa = mk_a(d32);
      p1 = $urandom_range(0, 2);
      if (p1 >= 1) cwa ^= 39'h1 << $urandom_range(0, 38);
      if (p1 == 2) cwa ^= 39'h1 << $urandom_range(0, 38);
      send_a(cwa, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin a_in_valid = 1'b0; @(posedge clk); #1; end
    end
    a_in_valid = 1'b0;
    a_mode = 1;
    drain("bp");

    // Full pipeline with stalled output
    a_mode = 0;
    @(posedge clk); #1;
    send_a(mk_a(32'h12345678), 1'b1);
    send_a(mk_a(32'h9ABCDEF0) ^ 39'h4, 1'b1);
    a_in_cw = mk_a(32'h0F0F0F0F);
    @(negedge clk);
    check("full_in_ready", 96'(a_in_ready), 96'(0));
    check("full_out_valid", 96'(a_out_valid), 96'(1));

    // Asynchronous reset with both stages full
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outs", {38'b0, a_out_valid, a_out_sgl, a_out_unc, a_out_syn, a_out_data, a_sgl_cnt, a_unc_cnt}, 96'(0));
    check("midrst_in_ready", 96'(a_in_ready), 96'(1));
    a_in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    a_mode = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk) check("no_stale_out", 96'(a_out_valid), 96'(0));
    end
    @(posedge clk); #1;

    // 64-bit: every single-bit flip across all 72 bits, back-to-back
    b_stall = 0;
    for (int p = 0; p < 72; p++) begin
      d64 = {$urandom, $urandom};
      send_b(mk_b(d64) ^ (72'h1 << p), 1'b1);
    end
    b_in_valid = 1'b0;
    check("b_full_rate", 96'(b_stall), 96'(0));
    drain("b_sgl");
    check("b_sgl_total", 96'(b_sgl_cnt), 96'(72));

    // 64-bit: random double flips under random backpressure
    b_mode = 2;
    for (int k = 0; k < 200; k++) begin
      d64 = {$urandom, $urandom};
      p1 = $urandom_range(0, 71);
      p2 = $urandom_range(0, 70);
      if (p2 >= p1) p2++;
      cwb = mk_b(d64) ^ (72'h1 << p1) ^ (72'h1 << p2);
      send_b(cwb, 1'b1);
    end
    b_in_valid = 1'b0;
    b_mode = 1;
    drain("b_dbl");
    check("b_unc_total", 96'(b_unc_cnt), 96'(200));
    check("b_sgl_after_dbl", 96'(b_sgl_cnt), 96'(72));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
